// File: rtl/dish_washer_ctrl_param.sv
// Dish-washer program sequencer: fill, detergent, timed wash, rinse passes, drain, dry.
// Internal cycle timers, fill/drain watchdogs and a latched fault state that only reset clears.
module dish_washer_ctrl_param #(
  parameter int WASH_CYCLES   = 16,
  parameter int RINSE_CYCLES  = 8,
  parameter int DRY_CYCLES    = 16,
  parameter int RINSE_PASSES  = 2,
  parameter int FILL_TIMEOUT  = 64,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int TIMER_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_classify,
  input  logic       i_filled,
  input  logic       i_drained,
  input  logic       i_detergent_added,
  output logic       o_fill_valve_on,
  output logic       o_fill_valve_second_on,
  output logic       o_drained_valve_on,
  output logic       o_door_lock,
  output logic       o_done,
  output logic       o_fault,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FILL       = 4'd1,
    S_DETERGENT  = 4'd2,
    S_WASH       = 4'd3,
    S_DRAIN      = 4'd4,
    S_RINSE_FILL = 4'd5,
    S_RINSE      = 4'd6,
    S_DRY        = 4'd7,
    S_DONE       = 4'd8,
    S_FAULT      = 4'd9
  } state_t;

  localparam int RC_W = (RINSE_PASSES < 1) ? 1 : $clog2(RINSE_PASSES + 1);

  localparam logic [TIMER_W-1:0] L_WASH       = TIMER_W'(WASH_CYCLES);
  localparam logic [TIMER_W-1:0] L_WASH_HEAVY = TIMER_W'(2 * WASH_CYCLES);
  localparam logic [TIMER_W-1:0] L_RINSE      = TIMER_W'(RINSE_CYCLES);
  localparam logic [TIMER_W-1:0] L_DRY        = TIMER_W'(DRY_CYCLES);
  localparam logic [TIMER_W-1:0] L_FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] L_DRAIN_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);

  state_t              r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [TIMER_W-1:0]  r_wdog;
  logic [RC_W-1:0]     r_rinseCnt;
  logic                r_heavy;

  logic w_timerLast;
  logic w_fillExpired;
  logic w_drainExpired;
  logic w_moreRinse;

  // Timer holds the cycles left including the current one; watchdog counts cycles already spent.
  assign w_timerLast    = (r_timer == TIMER_W'(1));
  assign w_fillExpired  = (r_wdog == L_FILL_LAST);
  assign w_drainExpired = (r_wdog == L_DRAIN_LAST);
  assign w_moreRinse    = ($signed({1'b0, r_rinseCnt}) < RINSE_PASSES);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_wdog     <= '0;
      r_rinseCnt <= '0;
      r_heavy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_FILL;
            r_heavy    <= i_classify;
            r_rinseCnt <= '0;
            r_wdog     <= '0;
          end
        end
        S_FILL: begin
          if (i_filled) begin
            r_state <= S_DETERGENT;
          end else if (w_fillExpired) begin
            r_state <= S_FAULT;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_DETERGENT: begin
          if (i_detergent_added) begin
            r_state <= S_WASH;
            r_timer <= r_heavy ? L_WASH_HEAVY : L_WASH;
          end
        end
        S_WASH: begin
          if (w_timerLast) begin
            r_state <= S_DRAIN;
            r_wdog  <= '0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_DRAIN: begin
          if (i_drained) begin
            if (w_moreRinse) begin
              r_state <= S_RINSE_FILL;
              r_wdog  <= '0;
            end else begin
              r_state <= S_DRY;
              r_timer <= L_DRY;
            end
          end else if (w_drainExpired) begin
            r_state <= S_FAULT;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RINSE_FILL: begin
          if (i_filled) begin
            r_state <= S_RINSE;
            r_timer <= L_RINSE;
          end else if (w_fillExpired) begin
            r_state <= S_FAULT;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RINSE: begin
          if (w_timerLast) begin
            r_state    <= S_DRAIN;
            r_wdog     <= '0;
            r_rinseCnt <= r_rinseCnt + 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_DRY: begin
          if (w_timerLast) begin
            r_state <= S_DONE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // In FAULT the door stays locked only until the tub reports empty.
  always_comb begin
    o_fill_valve_on        = 1'b0;
    o_fill_valve_second_on = 1'b0;
    o_drained_valve_on     = 1'b0;
    o_door_lock            = 1'b0;
    o_done                 = 1'b0;
    o_fault                = 1'b0;
    case (r_state)
      S_FILL, S_RINSE_FILL: begin
        o_fill_valve_on        = 1'b1;
        o_fill_valve_second_on = r_heavy;
        o_door_lock            = 1'b1;
      end
      S_DETERGENT, S_WASH, S_RINSE, S_DRY: begin
        o_door_lock = 1'b1;
      end
      S_DRAIN: begin
        o_drained_valve_on = 1'b1;
        o_door_lock        = 1'b1;
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      S_FAULT: begin
        o_fault            = 1'b1;
        o_drained_valve_on = 1'b1;
        o_door_lock        = ~i_drained;
      end
      default: begin
        o_done = 1'b0;
      end
    endcase
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_dish_washer_ctrl_param.sv
// Scoreboard bench for dish_washer_ctrl_param: expected state/outputs are queued as each
// cycle's inputs are driven and compared on the following falling edge.
module tb_dish_washer_ctrl_param;

  localparam int WASH  = 4;
  localparam int RINSE = 3;
  localparam int DRY   = 5;
  localparam int TOUT  = 8;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FILL = 4'd1, ST_DET = 4'd2, ST_WASH = 4'd3,
                         ST_DRAIN = 4'd4, ST_RFILL = 4'd5, ST_RINSE = 4'd6, ST_DRY = 4'd7,
                         ST_DONE = 4'd8, ST_FAULT = 4'd9;

  // Stimulus vector bits: {start, classify, filled, drained, detergent}
  localparam logic [4:0] I_NONE  = 5'b00000;
  localparam logic [4:0] I_START = 5'b10000;
  localparam logic [4:0] I_HEAVY = 5'b11000;
  localparam logic [4:0] I_FILL  = 5'b00100;
  localparam logic [4:0] I_DRAIN = 5'b00010;
  localparam logic [4:0] I_DET   = 5'b00001;

  typedef struct {
    logic       sel;
    logic [3:0] st;
    logic [5:0] outs;
  } expRec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, classify = 1'b0, filled = 1'b0, drained = 1'b0, det = 1'b0;
  logic start0 = 1'b0, classify0 = 1'b0, filled0 = 1'b0, drained0 = 1'b0, det0 = 1'b0;
  logic fillV, fill2V, drainV, lock, done, fault;
  logic fillV0, fill2V0, drainV0, lock0, done0, fault0;
  logic [3:0] state, state0;
  logic [5:0] mainOuts, zeroOuts;

  expRec_t sbQ[$];
  int errCount = 0;
  int checkCount = 0;
  logic expHeavy = 1'b0;

  assign mainOuts = {fillV, fill2V, drainV, lock, done, fault};
  assign zeroOuts = {fillV0, fill2V0, drainV0, lock0, done0, fault0};

  always #5 clk = ~clk;

  dish_washer_ctrl_param #(
    .WASH_CYCLES(WASH), .RINSE_CYCLES(RINSE), .DRY_CYCLES(DRY), .RINSE_PASSES(2),
    .FILL_TIMEOUT(TOUT), .DRAIN_TIMEOUT(TOUT), .TIMER_W(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_classify(classify), .i_filled(filled),
    .i_drained(drained), .i_detergent_added(det),
    .o_fill_valve_on(fillV), .o_fill_valve_second_on(fill2V), .o_drained_valve_on(drainV),
    .o_door_lock(lock), .o_done(done), .o_fault(fault), .o_state(state)
  );

  dish_washer_ctrl_param #(
    .WASH_CYCLES(WASH), .RINSE_CYCLES(RINSE), .DRY_CYCLES(DRY), .RINSE_PASSES(0),
    .FILL_TIMEOUT(TOUT), .DRAIN_TIMEOUT(TOUT), .TIMER_W(8)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_classify(classify0), .i_filled(filled0),
    .i_drained(drained0), .i_detergent_added(det0),
    .o_fill_valve_on(fillV0), .o_fill_valve_second_on(fill2V0), .o_drained_valve_on(drainV0),
    .o_door_lock(lock0), .o_done(done0), .o_fault(fault0), .o_state(state0)
  );

  // Reference output decode: {fill, fill2, drainValve, doorLock, done, fault}
  function automatic logic [5:0] expOuts(input logic [3:0] st, input logic hv, input logic dr);
    case (st)
      ST_FILL, ST_RFILL:               expOuts = {1'b1, hv, 1'b0, 1'b1, 1'b0, 1'b0};
      ST_DET, ST_WASH, ST_RINSE, ST_DRY: expOuts = 6'b000100;
      ST_DRAIN:                        expOuts = 6'b001100;
      ST_DONE:                         expOuts = 6'b000010;
      ST_FAULT:                        expOuts = {1'b0, 1'b0, 1'b1, ~dr, 1'b0, 1'b1};
      default:                         expOuts = 6'b000000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic popCompare();
    expRec_t e;
    e = sbQ.pop_front();
    if (e.sel == 1'b0) begin
      checkOutput("main.state", {4'h0, state}, {4'h0, e.st});
      checkOutput("main.outs", {2'b00, mainOuts}, {2'b00, e.outs});
    end else begin
      checkOutput("rp0.state", {4'h0, state0}, {4'h0, e.st});
      checkOutput("rp0.outs", {2'b00, zeroOuts}, {2'b00, e.outs});
    end
  endtask

  // Drive one cycle of inputs n times, queueing the state expected after each rising edge.
  task automatic applyStimulus(input logic sel, input logic [4:0] stim, input logic [3:0] st, input int n);
    expRec_t e;
    for (int i = 0; i < n; i++) begin
      if (sel == 1'b0) begin
        {start, classify, filled, drained, det} = stim;
        {start0, classify0, filled0, drained0, det0} = 5'b0;
      end else begin
        {start, classify, filled, drained, det} = 5'b0;
        {start0, classify0, filled0, drained0, det0} = stim;
      end
      e.sel  = sel;
      e.st   = st;
      e.outs = expOuts(st, sel ? 1'b0 : expHeavy, stim[1]);
      sbQ.push_back(e);
      @(posedge clk);
      @(negedge clk);
      popCompare();
      #1;
    end
  endtask

  // Full program from IDLE with sensors answering in the first cycle of each request.
  task automatic runProgram(input logic sel, input logic hv, input int passes, input logic [4:0] doneStim);
    int washLen;
    washLen = hv ? 2 * WASH : WASH;
    if (sel == 1'b0) expHeavy = hv;
    applyStimulus(sel, hv ? I_HEAVY : I_START, ST_FILL, 1);
    applyStimulus(sel, I_FILL, ST_DET, 1);
    applyStimulus(sel, I_DET, ST_WASH, 1);
    applyStimulus(sel, I_NONE, ST_WASH, washLen - 1);
    applyStimulus(sel, I_NONE, ST_DRAIN, 1);
    for (int p = 0; p < passes; p++) begin
      applyStimulus(sel, I_DRAIN, ST_RFILL, 1);
      applyStimulus(sel, I_FILL, ST_RINSE, 1);
      applyStimulus(sel, I_NONE, ST_RINSE, RINSE - 1);
      applyStimulus(sel, I_NONE, ST_DRAIN, 1);
    end
    applyStimulus(sel, I_DRAIN, ST_DRY, 1);
    applyStimulus(sel, I_NONE, ST_DRY, DRY - 1);
    applyStimulus(sel, I_NONE, ST_DONE, 1);
    applyStimulus(sel, doneStim, ST_IDLE, 1);
  endtask

  task automatic pulseResetCheck(input string tag);
    #2 rst = 1'b1;
    #1;
    checkOutput({tag, ".state"}, {4'h0, state}, 8'h00);
    checkOutput({tag, ".outs"}, {2'b00, mainOuts}, 8'h00);
    #1 rst = 1'b0;
    expHeavy = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset.state", {4'h0, state}, 8'h00);
    checkOutput("reset.outs", {2'b00, mainOuts}, 8'h00);
    checkOutput("reset.rp0", {state0, 2'b00, zeroOuts[1:0]}, 8'h00);
    #1 rst = 1'b0;

    // Normal load, then idle holds
    runProgram(1'b0, 1'b0, 2, I_NONE);
    applyStimulus(1'b0, I_NONE, ST_IDLE, 2);

    // Heavy load with Start held through DONE, then a normal restart whose fill times out
    runProgram(1'b0, 1'b1, 2, I_START);
    expHeavy = 1'b0;
    applyStimulus(1'b0, I_START, ST_FILL, 1);
    applyStimulus(1'b0, I_NONE, ST_FILL, TOUT - 1);
    applyStimulus(1'b0, I_NONE, ST_FAULT, 1);
    applyStimulus(1'b0, I_START, ST_FAULT, 2);
    applyStimulus(1'b0, I_DRAIN | I_START, ST_FAULT, 2);
    pulseResetCheck("faultReset");

    // Sensors answering in the last allowed watchdog cycle, then a drain that never completes
    applyStimulus(1'b0, I_START, ST_FILL, 1);
    applyStimulus(1'b0, I_FILL, ST_DET, 1);
    applyStimulus(1'b0, I_DET, ST_WASH, 1);
    applyStimulus(1'b0, I_NONE, ST_WASH, WASH - 1);
    applyStimulus(1'b0, I_NONE, ST_DRAIN, 1);
    applyStimulus(1'b0, I_NONE, ST_DRAIN, TOUT - 1);
    applyStimulus(1'b0, I_DRAIN, ST_RFILL, 1);
    applyStimulus(1'b0, I_NONE, ST_RFILL, TOUT - 1);
    applyStimulus(1'b0, I_FILL, ST_RINSE, 1);
    applyStimulus(1'b0, I_NONE, ST_RINSE, RINSE - 1);
    applyStimulus(1'b0, I_NONE, ST_DRAIN, 1);
    applyStimulus(1'b0, I_NONE, ST_DRAIN, TOUT - 1);
    applyStimulus(1'b0, I_NONE, ST_FAULT, 1);
    pulseResetCheck("drainFaultReset");

    // Reset in the middle of WASH, then a complete program
    applyStimulus(1'b0, I_START, ST_FILL, 1);
    applyStimulus(1'b0, I_FILL, ST_DET, 1);
    applyStimulus(1'b0, I_DET, ST_WASH, 1);
    applyStimulus(1'b0, I_NONE, ST_WASH, 1);
    pulseResetCheck("washReset");
    runProgram(1'b0, 1'b0, 2, I_NONE);

    // Build without rinse passes goes straight from DRAIN to DRY
    runProgram(1'b1, 1'b0, 0, I_NONE);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete, errors=%0d", errCount);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dish_washer_ctrl_param.md
# dish_washer_ctrl_param

Parametrised next-generation dish-washer cycle controller. It sequences fill, detergent, wash, N rinse passes, drain and dry, and it times wash, rinse and dry internally instead of relying on external timeout strobes. It adds a heavy-load mode and fill/drain watchdogs with a latched fault state. It sits between the front-panel/sensor inputs and the valve and door-lock actuators.

## Interface
Parameters:
- WASH_CYCLES, 16: clocks spent in WASH (normal load); must be ≥1.
- RINSE_CYCLES, 8: clocks per RINSE pass; must be ≥1.
- DRY_CYCLES, 16: clocks in DRY; must be ≥1.
- RINSE_PASSES, 2: rinse passes after the wash; 0 is legal.
- FILL_TIMEOUT, 64: max clocks in a fill state before fault.
- DRAIN_TIMEOUT, 64: max clocks in DRAIN before fault.
- TIMER_W, 8: timer and watchdog width; must hold 2*WASH_CYCLES, FILL_TIMEOUT and DRAIN_TIMEOUT.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level; begins a program from IDLE.
- Classify  in  1  heavy-load select, sampled only with Start in IDLE.
- Filled  in  1  tub-full sensor.
- Drained  in  1  tub-empty sensor.
- Detergent_Added  in  1  detergent dispensed.
- Fill_valve_on  out  1  main fill valve.
- Fill_valve_second_on  out  1  second fill valve (heavy load only).
- Drained_valve_on  out  1  drain valve.
- Door_Lock  out  1  door locked.
- Done  out  1  one-cycle end-of-program pulse.
- Fault  out  1  latched watchdog fault.
- State  out  4  current state code.

## Operation
- States and codes: IDLE 0, FILL 1, DETERGENT 2, WASH 3, DRAIN 4, RINSE_FILL 5, RINSE 6, DRY 7, DONE 8, FAULT 9. Codes 10–15 are unreachable; if entered, the next state is IDLE.
- Outputs are Moore-decoded from the state register plus the heavy flag.
- IDLE: all outputs 0. Start=1 → FILL. Classify is latched into heavy, and the rinse counter is cleared.
- FILL: Fill_valve_on=1, Fill_valve_second_on=heavy, Door_Lock=1. Filled=1 → DETERGENT.
- DETERGENT: Door_Lock=1. Detergent_Added=1 → WASH. The timer loads WASH_CYCLES, or 2*WASH_CYCLES when heavy.
- WASH: Door_Lock=1. The controller stays exactly the loaded number of cycles, then → DRAIN.
- DRAIN: Drained_valve_on=1, Door_Lock=1. On Drained=1:
  - rinse count < RINSE_PASSES → RINSE_FILL;
  - otherwise → DRY (timer=DRY_CYCLES).
- RINSE_FILL: same outputs as FILL. Filled=1 → RINSE (timer=RINSE_CYCLES).
- RINSE: Door_Lock=1. After RINSE_CYCLES cycles → DRAIN, and the rinse count increments.
- DRY: Door_Lock=1. After DRY_CYCLES cycles → DONE.
- DONE: Done=1, Door_Lock=0. Unconditionally → IDLE next cycle.
- Watchdog:
  - It clears on entry to FILL, RINSE_FILL or DRAIN and increments each cycle spent there.
  - If the awaited sensor is still 0 in the FILL_TIMEOUT-th cycle (DRAIN_TIMEOUT-th for DRAIN) → FAULT.
  - The sensor has priority over the timeout in the same cycle.
- FAULT: Fault=1; fill valves 0; Drained_valve_on=1.
  - Door_Lock=1 while Drained=0 and 0 once Drained=1.
  - FAULT exits only via Reset; Start is ignored.
- Start, Classify and the sensors are ignored outside the states that sample them.

## Timing
- Reset: state=IDLE; timer, watchdog, rinse count and heavy flag =0; every output 0, State=0. Reset mid-program aborts immediately, and valves close asynchronously.
- Start sampled at edge k in IDLE → FILL outputs valid after edge k (1-cycle latency). Every sensor-driven transition likewise takes effect at the next edge.
- WASH, RINSE and DRY occupy exactly their programmed cycle counts; the state changes at the edge closing the last cycle.
- Done is high for exactly one cycle; IDLE follows. Start held high restarts a new program the cycle after IDLE.
- Inputs are assumed synchronous to Clock; synchronisers are external.

## Test plan
Parameters for all scenarios: WASH=4, RINSE=3, DRY=5, RINSE_PASSES=2, FILL_TIMEOUT=DRAIN_TIMEOUT=8.
- Normal load, sensors answer 1 cycle after each request:
  - State sequence 0,1,2,3×4,4,5,6×3,4,5,6×3,4,7×5,8,0.
  - Fill_valve_second_on never 1; Done high exactly 1 cycle; Door_Lock low only in IDLE/DONE.
- Heavy load (Classify=1 with Start): WASH lasts 8 cycles; Fill_valve_second_on=1 in every FILL and RINSE_FILL cycle.
- Filled never asserted: FAULT after 8 FILL cycles, Fault=1, Drained_valve_on=1. Door_Lock drops when Drained=1; state stays 9 despite Start=1 until Reset.
- Drained asserted in the 8th DRAIN cycle → proceeds (no fault). Never asserted → FAULT after 8 cycles.
- RINSE_PASSES=0 build: DRAIN → DRY directly after WASH; RINSE states never visited.
- Reset pulsed mid-WASH between edges: all outputs 0 immediately. State=0, and the next Start runs a full program from FILL.
